// File: rtl/uart_pixel_packer.sv
// Byte-stream to 12-bit pixel packer: hunts a 2-byte header, packs byte pairs, counts W*H pixels.
// Optional trailing XOR checksum byte qualifies frame_done when PIX_CHECKSUM_EN is defined.
module uart_pixel_packer #(
  parameter int unsigned W       = 50,
  parameter int unsigned H       = 40,
  parameter logic [7:0]  HDR0    = 8'hAA,
  parameter logic [7:0]  HDR1    = 8'h55,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        rx_valid,
  output logic [11:0] rx_data,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [14:0] pix_cnt
);

  localparam int unsigned NPIX     = W * H;
  localparam int unsigned TOW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [14:0] LAST_PIX = 15'(NPIX);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
  localparam bit          TO_EN    = (TIMEOUT != 0);

  typedef enum logic [2:0] {HUNT0, HUNT1, LO, HI, CSUM} state_e;

  state_e          state_q, state_d;
  logic [3:0]      nib_q, nib_d;
  logic            rx_valid_q, rx_valid_d;
  logic [11:0]     rx_data_q, rx_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [14:0]     pix_cnt_q, pix_cnt_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic [14:0]     pix_next;
`ifdef PIX_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  assign pix_next = pix_cnt_q + 15'd1;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT0;
      nib_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pix_cnt_q  <= '0;
      to_cnt_q   <= '0;
`ifdef PIX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pix_cnt_q  <= pix_cnt_d;
      to_cnt_q   <= to_cnt_d;
`ifdef PIX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state: byte handling has priority; idle clocks advance the abort counter
  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pix_cnt_d  = pix_cnt_q;
    to_cnt_d   = '0;
`ifdef PIX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (byte_valid) begin
      case (state_q)
        HUNT0: if (byte_data == HDR0) state_d = HUNT1;
        HUNT1: begin
          if (byte_data == HDR1) begin
            state_d   = LO;
            busy_d    = 1'b1;
            pix_cnt_d = '0;
`ifdef PIX_CHECKSUM_EN
            csum_d    = '0;
`endif
          end else if (byte_data != HDR0) begin
            state_d = HUNT0;
          end
        end
        LO: begin
          nib_d   = byte_data[3:0];
          state_d = HI;
`ifdef PIX_CHECKSUM_EN
          csum_d  = csum_q ^ byte_data;
`endif
        end
        HI: begin
          rx_valid_d = 1'b1;
          rx_data_d  = {nib_q, byte_data};
          pix_cnt_d  = pix_next;
`ifdef PIX_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          if (pix_next == LAST_PIX) begin
`ifdef PIX_CHECKSUM_EN
            state_d = CSUM;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = HUNT0;
`endif
          end else begin
            state_d = LO;
          end
        end
`ifdef PIX_CHECKSUM_EN
        CSUM: begin
          done_d  = (byte_data == csum_q);
          err_d   = (byte_data != csum_q);
          busy_d  = 1'b0;
          state_d = HUNT0;
        end
`endif
        default: state_d = HUNT0;
      endcase
    end else if (state_q != HUNT0) begin
      if (TO_EN && (to_cnt_q == TO_LAST)) begin
        err_d     = 1'b1;
        busy_d    = 1'b0;
        pix_cnt_d = '0;
        state_d   = HUNT0;
      end else begin
        to_cnt_d = to_cnt_q + TOW'(1);
      end
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Scoreboard bench for uart_pixel_packer; expected pixels are queued as bytes are driven.
// Define PIX_CHECKSUM_EN for both files to exercise the checksum build.
module tb_uart_pixel_packer;

  localparam int unsigned W       = 50;
  localparam int unsigned H       = 40;
  localparam int unsigned NPIX    = W * H;
  localparam int unsigned TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        rx_valid;
  logic [11:0] rx_data;
  logic        frame_busy;
  logic        frame_done;
  logic        frame_err;
  logic [14:0] pix_cnt;

  always #5 clk = ~clk;

  uart_pixel_packer #(
    .W(W), .H(H), .HDR0(8'hAA), .HDR1(8'h55), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_err(frame_err), .pix_cnt(pix_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int sent_cyc = 0;
  int rx_seen = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic prev_rx = 1'b0;
  logic [26:0] exp_q[$];
  logic [26:0] e_px;
`ifdef PIX_CHECKSUM_EN
  logic [7:0] csum;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every pixel strobe
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_seen++;
      check("rx_back_to_back", 32'(prev_rx), 32'd0);
      if (exp_q.size() == 0) begin
        check("px_unexpected_qsize", exp_q.size(), 32'd1);
      end else begin
        e_px = exp_q.pop_front();
        check("px_data", 32'(rx_data), 32'(e_px[11:0]));
        check("px_cnt", 32'(pix_cnt), 32'(e_px[26:12]));
        check("px_latency", cyc, sent_cyc);
      end
    end
    if (frame_done) begin
      done_seen++;
`ifndef PIX_CHECKSUM_EN
      check("done_with_last_px", 32'({rx_valid, pix_cnt}), 32'({1'b1, 15'(NPIX)}));
`endif
    end
    if (frame_err) err_seen++;
    prev_rx = rx_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    byte_data  = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    sent_cyc   = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1, input int idx);
    exp_q.push_back({15'(idx), b0[3:0], b1});
`ifdef PIX_CHECKSUM_EN
    csum = csum ^ b0 ^ b1;
`endif
    send_byte(b0);
    send_byte(b1);
  endtask

  // Full payload; header bytes are sprinkled in when with_pairs is set
  task automatic send_frame(input bit with_pairs);
    logic [7:0] b0, b1;
`ifdef PIX_CHECKSUM_EN
    csum = 8'h00;
`endif
    for (int i = 0; i < int'(NPIX); i++) begin
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      if (with_pairs && (i % 100 == 7)) begin b0 = 8'hAA; b1 = 8'h55; end
      if (with_pairs && (i % 100 == 8)) begin b0 = 8'h55; b1 = 8'hAA; end
      send_pixel(b0, b1, i + 1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_busy"}, 32'(frame_busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
    check({tag, "_pix_cnt"}, 32'(pix_cnt), 32'd0);
  endtask

  initial begin
    int rx0, done0, err0;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    idle(3);
    rst = 1'b0;
    check_idle_outputs("reset");

    // Single pixel, then a dangling LO byte that times out
    rx0 = rx_seen; err0 = err_seen;
    send_byte(8'hAA);
    send_byte(8'h55);
    check("hdr_busy", 32'(frame_busy), 32'd1);
    check("hdr_pix_cnt", 32'(pix_cnt), 32'd0);
    send_pixel(8'h0F, 8'h12, 1);
    idle(2);
    check("px1_count", rx_seen - rx0, 32'd1);
    check("px1_pix_cnt", 32'(pix_cnt), 32'd1);
    send_byte(8'h34);
    idle(TIMEOUT + 5);
    check("to_err_pulses", err_seen - err0, 32'd1);
    check("to_busy", 32'(frame_busy), 32'd0);
    check("to_pix_cnt", 32'(pix_cnt), 32'd0);
    check("to_rx_count", rx_seen - rx0, 32'd1);
    check("to_rx_data_hold", 32'(rx_data), 32'hF12);

    // New header after abort, then reset between LO and HI
    rx0 = rx_seen;
    send_byte(8'hAA);
    send_byte(8'h55);
    check("rehdr_busy", 32'(frame_busy), 32'd1);
    send_byte(8'h01);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    check_idle_outputs("midrst");
    check("midrst_rx_count", rx_seen - rx0, 32'd0);

    // Noise before the header, payload containing header pairs
    rx0 = rx_seen; done0 = done_seen; err0 = err_seen;
    send_byte(8'h12);
    send_byte(8'hAA);
    send_byte(8'hAA);
    send_byte(8'h55);
    check("frame_busy_start", 32'(frame_busy), 32'd1);
    send_frame(1'b1);
`ifdef PIX_CHECKSUM_EN
    check("csum_wait_busy", 32'(frame_busy), 32'd1);
    send_byte(csum);
`endif
    idle(4);
    check("frame_rx_count", rx_seen - rx0, NPIX);
    check("frame_done_pulses", done_seen - done0, 32'd1);
    check("frame_err_pulses", err_seen - err0, 32'd0);
    check("frame_busy_end", 32'(frame_busy), 32'd0);
    check("frame_pix_cnt", 32'(pix_cnt), NPIX);
    check("frame_q_empty", exp_q.size(), 32'd0);

`ifdef PIX_CHECKSUM_EN
    // Wrong checksum byte flags an error and no done
    rx0 = rx_seen; done0 = done_seen; err0 = err_seen;
    send_byte(8'hAA);
    send_byte(8'h55);
    send_frame(1'b0);
    send_byte(csum ^ 8'hFF);
    idle(4);
    check("badcs_rx_count", rx_seen - rx0, NPIX);
    check("badcs_done_pulses", done_seen - done0, 32'd0);
    check("badcs_err_pulses", err_seen - err0, 32'd1);
    check("badcs_busy", 32'(frame_busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
